// File: rtl/dmem_arb_pkg.sv
// Shared types and default constants for the DataMem arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RDWAIT
    } state_t;

    typedef enum logic {
        CORE = 1'b0,
        HOST = 1'b1
    } requester_t;

    localparam int unsigned DEF_DATA_W        = 16;
    localparam int unsigned DEF_ADDR_W        = 16;
    localparam int unsigned DEF_HOST_MAX_WAIT = 8;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection between core and host requesters.
module dmem_arb_pick
    import dmem_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic       core_req,
    input  logic       host_req,
    input  requester_t last_grant,
    input  logic       age_hit,
    output logic       any_req,
    output requester_t winner
);

    always_comb begin
        any_req = core_req | host_req;
        winner  = CORE;
        if (core_req && host_req) begin
            // Ties: round-robin alternates away from the last grant; fixed priority
            // favours core unless the host has aged out.
            if (RR_EN) begin
                winner = (last_grant == CORE) ? HOST : CORE;
            end else begin
                winner = age_hit ? HOST : CORE;
            end
        end else if (host_req) begin
            winner = HOST;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester (core/host) arbiter for a single-port DataMem.
// Define DMEM_ARB_RR_EN for round-robin ties; default is fixed priority with host aging.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned DATA_W        = DEF_DATA_W,
    parameter int unsigned ADDR_W        = DEF_ADDR_W,
    parameter int unsigned HOST_MAX_WAIT = DEF_HOST_MAX_WAIT
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

`ifdef DMEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    state_t            state;
    state_t            state_next;
    requester_t        winner;
    requester_t        last_grant;
    requester_t        lat_winner;
    logic              any_req;
    logic              age_hit;
    logic              take;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] core_rdata_q;
    logic [DATA_W-1:0] host_rdata_q;

    dmem_arb_pick #(
        .RR_EN (RR_EN)
    ) u_pick (
        .core_req   (core_req),
        .host_req   (host_req),
        .last_grant (last_grant),
        .age_hit    (age_hit),
        .any_req    (any_req),
        .winner     (winner)
    );

`ifdef DMEM_ARB_RR_EN
    assign age_hit = 1'b0;
`else
    localparam int unsigned AGE_W = $clog2(HOST_MAX_WAIT + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(HOST_MAX_WAIT);

    logic [AGE_W-1:0] age_cnt;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            age_cnt <= '0;
        end else if (take && (winner == HOST)) begin
            age_cnt <= '0;
        end else if (host_req && (age_cnt != AGE_MAX)) begin
            age_cnt <= age_cnt + 1'b1;
        end
    end

    assign age_hit = (age_cnt >= AGE_MAX);
`endif

    always_comb begin
        state_next  = state;
        take        = 1'b0;
        core_gnt    = 1'b0;
        host_gnt    = 1'b0;
        core_rvalid = 1'b0;
        host_rvalid = 1'b0;
        mem_we      = 1'b0;
        core_rdata  = core_rdata_q;
        host_rdata  = host_rdata_q;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    take       = 1'b1;
                    // Grants are masked while reset is held so outputs read 0 immediately.
                    core_gnt   = Reset & (winner == CORE);
                    host_gnt   = Reset & (winner == HOST);
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                mem_we     = lat_we;
                state_next = lat_we ? IDLE : RDWAIT;
            end
            RDWAIT: begin
                if (lat_winner == CORE) begin
                    core_rvalid = 1'b1;
                    core_rdata  = mem_dout;
                end else begin
                    host_rvalid = 1'b1;
                    host_rdata  = mem_dout;
                end
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state        <= IDLE;
            lat_winner   <= CORE;
            last_grant   <= HOST;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            core_rdata_q <= '0;
            host_rdata_q <= '0;
        end else begin
            state <= state_next;
            if (take) begin
                lat_winner <= winner;
                last_grant <= winner;
                if (winner == CORE) begin
                    lat_we    <= core_we;
                    lat_addr  <= core_addr;
                    lat_wdata <= core_wdata;
                end else begin
                    lat_we    <= host_we;
                    lat_addr  <= host_addr;
                    lat_wdata <= host_wdata;
                end
            end
            if (core_rvalid) begin
                core_rdata_q <= mem_dout;
            end
            if (host_rvalid) begin
                host_rdata_q <= mem_dout;
            end
        end
    end

    assign mem_addr = lat_addr;
    assign mem_din  = lat_wdata;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: transaction-level model predicts grants and memory events.
module tb_dmem_arbiter;

    localparam int DW   = 16;
    localparam int AW   = 16;
    localparam int MAXW = 8;

    logic          CLK = 1'b0;
    logic          Reset = 1'b0;
    logic          core_req = 1'b0, core_we = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic          host_req = 1'b0, host_we = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          core_gnt, core_rvalid, host_gnt, host_rvalid, mem_we, busy;
    logic [DW-1:0] core_rdata, host_rdata, mem_din, mem_dout;
    logic [AW-1:0] mem_addr;

    dmem_arbiter #(
        .DATA_W        (DW),
        .ADDR_W        (AW),
        .HOST_MAX_WAIT (MAXW)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .core_req    (core_req),
        .core_we     (core_we),
        .core_addr   (core_addr),
        .core_wdata  (core_wdata),
        .core_gnt    (core_gnt),
        .core_rvalid (core_rvalid),
        .core_rdata  (core_rdata),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_we      (mem_we),
        .mem_dout    (mem_dout),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endfunction

    function automatic logic [DW-1:0] seed(input int k);
        return DW'(k * 40503 + 4660);
    endfunction

    // DataMem: registered read, write on mem_we.
    logic [DW-1:0] dut_mem [int];
    int            dk;
    always @(posedge CLK) begin
        dk = int'(mem_addr[7:0]);
        mem_dout <= dut_mem.exists(dk) ? dut_mem[dk] : seed(dk);
        if (mem_we) dut_mem[dk] = mem_din;
    end

    // Reference model: kind 0 = write, 1 = core read, 2 = host read.
    typedef struct {
        int            kind;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] ref_mem [int];
    int            m_wait = 0;
    int            m_last = 1;
    int            m_age  = 0;
    int            m_w;
    int            rk;
    logic          t_we;
    logic [AW-1:0] t_addr;
    logic [DW-1:0] t_data;

    always @(negedge CLK) begin
        if (!Reset) begin
            m_wait = 0;
            m_last = 1;
            m_age  = 0;
            exp_q.delete();
            chk("rst_core_gnt", core_gnt, 0);
            chk("rst_host_gnt", host_gnt, 0);
            chk("rst_rvalid", {core_rvalid, host_rvalid}, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_busy", busy, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_din", mem_din, 0);
            chk("rst_rdata", {core_rdata, host_rdata}, 0);
        end else begin
            m_w = -1;
            if (m_wait == 0 && (core_req || host_req)) begin
                if (core_req && host_req) begin
`ifdef DMEM_ARB_RR_EN
                    m_w = (m_last == 1) ? 0 : 1;
`else
                    m_w = (m_age >= MAXW) ? 1 : 0;
`endif
                end else begin
                    m_w = core_req ? 0 : 1;
                end
            end
            chk("core_gnt", core_gnt, m_w == 0);
            chk("host_gnt", host_gnt, m_w == 1);
            chk("busy", busy, m_wait != 0);
            if (host_req && m_w != 1) m_age = (m_age < MAXW) ? m_age + 1 : MAXW;
            if (m_w == 1) m_age = 0;
            if (m_w >= 0) begin
                t_we   = (m_w == 0) ? core_we : host_we;
                t_addr = (m_w == 0) ? core_addr : host_addr;
                t_data = (m_w == 0) ? core_wdata : host_wdata;
                rk     = int'(t_addr[7:0]);
                if (t_we) begin
                    ref_mem[rk] = t_data;
                    exp_q.push_back('{0, t_addr, t_data, cyc + 1});
                    m_wait = 1;
                end else begin
                    exp_q.push_back('{m_w + 1, t_addr,
                                      ref_mem.exists(rk) ? ref_mem[rk] : seed(rk), cyc + 2});
                    m_wait = 2;
                end
                m_last = m_w;
            end else if (m_wait > 0) begin
                m_wait--;
            end
        end
    end

    function automatic void check_evt(input int kind, input logic [DW-1:0] d);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d, want no event (cycle %0d)", kind, cyc);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", kind, e.kind);
        chk("event_cycle", cyc, e.due);
        if (kind == 0) begin
            chk("mem_addr", mem_addr, e.addr);
            chk("mem_din", mem_din, e.data);
        end else begin
            chk("rdata", d, e.data);
        end
    endfunction

    // Monitor: pops expectations whenever the DUT presents a memory write or read data.
    always @(negedge CLK) begin
        if (Reset) begin
            if (mem_we) check_evt(0, '0);
            if (core_rvalid) check_evt(1, core_rdata);
            if (host_rvalid) check_evt(2, host_rdata);
            if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                n_tests++;
                n_fail++;
                $display("FAIL missing_event: got nothing by cycle %0d, want kind %0d due %0d",
                         cyc, exp_q[0].kind, exp_q[0].due);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic rand_core();
        core_req   = ($urandom_range(0, 3) != 0);
        core_we    = 1'($urandom_range(0, 1));
        core_addr  = AW'($urandom_range(0, 15)) | (AW'($urandom_range(0, 3)) << 12);
        core_wdata = DW'($urandom);
    endtask

    task automatic rand_host();
        host_req   = ($urandom_range(0, 3) != 0);
        host_we    = 1'($urandom_range(0, 1));
        host_addr  = AW'($urandom_range(0, 15)) | (AW'($urandom_range(0, 3)) << 12);
        host_wdata = DW'($urandom);
    endtask

    // mode 0: drop req after grant; 1: random new transaction; 2: hold req.
    task automatic run_cycles(input int n, input int mode);
        logic cg, hg;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            cg = core_gnt;
            hg = host_gnt;
            @(posedge CLK);
            #1;
            if (cg) begin
                if (mode == 0) core_req = 1'b0;
                else if (mode == 1) rand_core();
            end else if (mode == 1 && !core_req && $urandom_range(0, 1) == 1) begin
                rand_core();
            end
            if (hg) begin
                if (mode == 0) host_req = 1'b0;
                else if (mode == 1) rand_host();
            end else if (mode == 1 && !host_req && $urandom_range(0, 1) == 1) begin
                rand_host();
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        Reset = 1'b1;

        // Both requesters held with writes straight after reset.
        core_req = 1'b1; core_we = 1'b1; core_addr = 16'h0001; core_wdata = 16'hAAAA;
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0002; host_wdata = 16'h5555;
        run_cycles(24, 2);
        core_req = 1'b0;
        host_req = 1'b0;
        run_cycles(3, 0);

        // Core write alone.
        core_req = 1'b1; core_we = 1'b1; core_addr = 16'h0010; core_wdata = 16'hBEEF;
        run_cycles(4, 0);

        // Seed 0x1234 then host read of it.
        core_req = 1'b1; core_we = 1'b1; core_addr = 16'h0020; core_wdata = 16'h1234;
        run_cycles(3, 0);
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0020;
        run_cycles(4, 0);
        chk("host_rdata_hold", host_rdata, 16'h1234);
        chk("core_rdata_untouched", core_rdata, 16'h0000);

        // Reset during RDWAIT of a core read, host pending.
        core_req = 1'b1; core_we = 1'b0; core_addr = 16'h0010;
        run_cycles(1, 0);
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0030; host_wdata = 16'h7777;
        @(posedge CLK);
        #2;
        Reset = 1'b0;
        #1;
        chk("rst_mid_core_rvalid", core_rvalid, 0);
        chk("rst_mid_gnt", {core_gnt, host_gnt}, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_mem", {mem_we, mem_addr, mem_din}, 0);
        chk("rst_mid_rdata", core_rdata, 0);
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        run_cycles(4, 0);

        // Randomized traffic.
        run_cycles(400, 1);
        run_cycles(12, 0);
        core_req = 1'b0;
        host_req = 1'b0;
        run_cycles(4, 0);
        chk("drain_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
